// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM state encoding, instruction error codes and AXI4 read-channel constants.
package ifu_pkg;

    localparam int XLEN     = 32;
    localparam int AXI_ID_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        VALID = 3'd3,
        DRAIN = 3'd4
    } fetch_state_t;

    localparam logic [1:0] INST_ERR_OK       = 2'b00;
    localparam logic [1:0] INST_ERR_BUS      = 2'b01;
    localparam logic [1:0] INST_ERR_MISALIGN = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// AXI4 read-only channel bundle (AR + R) between the fetch unit and the interconnect.
interface ifu_axi_fetch_if;
    import ifu_pkg::*;

    logic                arready;
    logic                arvalid;
    logic [XLEN-1:0]     araddr;
    logic [AXI_ID_W-1:0] arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                rready;
    logic                rvalid;
    logic [XLEN-1:0]     rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [AXI_ID_W-1:0] rid;

    modport master (
        input  arready,
        output arvalid,
        output araddr,
        output arid,
        output arlen,
        output arsize,
        output arburst,
        output rready,
        input  rvalid,
        input  rdata,
        input  rresp,
        input  rlast,
        input  rid
    );

    modport slave (
        output arready,
        input  arvalid,
        input  araddr,
        input  arid,
        input  arlen,
        input  arsize,
        input  arburst,
        input  rready,
        output rvalid,
        output rdata,
        output rresp,
        output rlast,
        output rid
    );

endinterface

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: owns the PC, issues one single-beat AXI4 read per instruction,
// hands the result to the core over valid/ready and squashes fetches made stale by redirects.
module ifu_axi_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [3:0]  AXI_ID   = 4'd0
) (
    input  logic               clock,
    input  logic               reset,
    ifu_axi_fetch_if.master    io_master,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [XLEN-1:0]    inst,
    output logic [XLEN-1:0]    inst_pc,
    output logic [1:0]         inst_err,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               fetch_busy
);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] pc_reg;
    logic            kill_reg;
    logic [XLEN-1:0] araddr_reg;
    logic            arvalid_reg;
    logic            rready_reg;
    logic            inst_valid_reg;
    logic [XLEN-1:0] inst_reg;
    logic [XLEN-1:0] inst_pc_reg;
    logic [1:0]      inst_err_reg;

    // Single-beat transfers: the response id/last carry no information here.
    logic unused_axi_bits;
    assign unused_axi_bits = ^{io_master.rlast, io_master.rid};

    assign io_master.arvalid = arvalid_reg;
    assign io_master.araddr  = araddr_reg;
    assign io_master.arid    = AXI_ID;
    assign io_master.arlen   = LEN_SINGLE;
    assign io_master.arsize  = SIZE_4B;
    assign io_master.arburst = BURST_INCR;
    assign io_master.rready  = rready_reg;

    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign inst_pc    = inst_pc_reg;
    assign inst_err   = inst_err_reg;
    assign fetch_busy = (state_reg != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            kill_reg       <= 1'b0;
            araddr_reg     <= '0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            inst_err_reg   <= INST_ERR_OK;
        end else begin
            // A redirect updates the PC in every state and beats the sequential increment.
            if (redirect_valid) begin
                pc_reg <= redirect_pc;
            end

            case (state_reg)
                IDLE: begin
                    if (!redirect_valid) begin
                        if (pc_misaligned(pc_reg)) begin
                            state_reg      <= VALID;
                            inst_valid_reg <= 1'b1;
                            inst_reg       <= '0;
                            inst_pc_reg    <= pc_reg;
                            inst_err_reg   <= INST_ERR_MISALIGN;
                        end else begin
                            state_reg   <= ADDR;
                            arvalid_reg <= 1'b1;
                            araddr_reg  <= pc_reg;
                        end
                    end
                end

                ADDR: begin
                    // The request cannot be withdrawn, so a redirect only marks it for draining.
                    if (redirect_valid) begin
                        kill_reg <= 1'b1;
                    end
                    if (io_master.arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        if (kill_reg || redirect_valid) begin
                            state_reg <= DRAIN;
                            kill_reg  <= 1'b0;
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (io_master.rvalid) begin
                        rready_reg <= 1'b0;
                        if (redirect_valid) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg      <= VALID;
                            inst_valid_reg <= 1'b1;
                            inst_pc_reg    <= pc_reg;
                            if (io_master.rresp != RESP_OKAY) begin
                                inst_reg     <= '0;
                                inst_err_reg <= INST_ERR_BUS;
                            end else begin
                                inst_reg     <= io_master.rdata;
                                inst_err_reg <= INST_ERR_OK;
                            end
                        end
                    end else if (redirect_valid) begin
                        state_reg <= DRAIN;
                    end
                end

                VALID: begin
                    if (redirect_valid) begin
                        state_reg      <= IDLE;
                        inst_valid_reg <= 1'b0;
                    end else if (inst_ready) begin
                        state_reg      <= IDLE;
                        inst_valid_reg <= 1'b0;
                        pc_reg         <= pc_incr(pc_reg);
                    end
                end

                DRAIN: begin
                    if (io_master.rvalid) begin
                        state_reg  <= IDLE;
                        rready_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg      <= IDLE;
                    kill_reg       <= 1'b0;
                    arvalid_reg    <= 1'b0;
                    rready_reg     <= 1'b0;
                    inst_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: per-cycle vector tables with hand-computed expectations,
// plus a hand-written asynchronous reset sequence in the middle of a fetch.
module tb_ifu_axi_fetch;
    import ifu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_busy;

    always #5 clock = ~clock;

    ifu_axi_fetch_if bus ();

    ifu_axi_fetch #(
        .RESET_PC (32'h8000_0000),
        .AXI_ID   (4'd0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .io_master      (bus),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_busy     (fetch_busy)
    );

    typedef struct {
        logic        arready;
        logic        rvalid;
        logic [1:0]  rresp;
        logic        inst_ready;
        logic        redir;
        logic [31:0] rdata;
        logic [31:0] redir_pc;
        logic        e_arvalid;
        logic        e_rready;
        logic        e_ivalid;
        logic        e_busy;
        logic [31:0] e_araddr;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [1:0]  e_err;
    } vec_t;

    // Expected {arvalid, rready, inst_valid, fetch_busy} for each FSM state.
    localparam logic [3:0] E_IDLE  = 4'b0000;
    localparam logic [3:0] E_ADDR  = 4'b1001;
    localparam logic [3:0] E_DATA  = 4'b0101;
    localparam logic [3:0] E_VALID = 4'b0011;
    localparam logic [3:0] E_DRAIN = 4'b0101;

    vec_t seg1[$];
    vec_t seg2[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   ar_count = 0;

    always @(posedge clock) begin
        if (reset && bus.arvalid && bus.arready) ar_count++;
    end

    // ins = {arready, rvalid, rresp[1:0], inst_ready, redirect_valid}
    function automatic vec_t mk(input logic [5:0] ins, input logic [31:0] rdata,
                                input logic [31:0] rpc, input logic [3:0] ex,
                                input logic [31:0] eaddr, input logic [31:0] einst,
                                input logic [31:0] eipc, input logic [1:0] eerr);
        vec_t v;
        v.arready    = ins[5];
        v.rvalid     = ins[4];
        v.rresp      = ins[3:2];
        v.inst_ready = ins[1];
        v.redir      = ins[0];
        v.rdata      = rdata;
        v.redir_pc   = rpc;
        v.e_arvalid  = ex[3];
        v.e_rready   = ex[2];
        v.e_ivalid   = ex[1];
        v.e_busy     = ex[0];
        v.e_araddr   = eaddr;
        v.e_inst     = einst;
        v.e_ipc      = eipc;
        v.e_err      = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge: check the registered outputs, then drive this cycle's inputs.
    task automatic apply(input string tag, input int idx, input vec_t v);
        check($sformatf("%s[%0d] arvalid", tag, idx), {31'd0, bus.arvalid}, {31'd0, v.e_arvalid});
        check($sformatf("%s[%0d] rready", tag, idx), {31'd0, bus.rready}, {31'd0, v.e_rready});
        check($sformatf("%s[%0d] inst_valid", tag, idx), {31'd0, inst_valid}, {31'd0, v.e_ivalid});
        check($sformatf("%s[%0d] fetch_busy", tag, idx), {31'd0, fetch_busy}, {31'd0, v.e_busy});
        if (v.e_arvalid)
            check($sformatf("%s[%0d] araddr", tag, idx), bus.araddr, v.e_araddr);
        if (v.e_ivalid) begin
            check($sformatf("%s[%0d] inst", tag, idx), inst, v.e_inst);
            check($sformatf("%s[%0d] inst_pc", tag, idx), inst_pc, v.e_ipc);
            check($sformatf("%s[%0d] inst_err", tag, idx), {30'd0, inst_err}, {30'd0, v.e_err});
        end
        $display("[TB] %s[%0d] arvalid=%b araddr=%h rready=%b inst_valid=%b inst=%h pc=%h err=%b",
                 tag, idx, bus.arvalid, bus.araddr, bus.rready, inst_valid, inst, inst_pc, inst_err);
        bus.arready    = v.arready;
        bus.rvalid     = v.rvalid;
        bus.rresp      = v.rresp;
        bus.rdata      = v.rdata;
        inst_ready     = v.inst_ready;
        redirect_valid = v.redir;
        redirect_pc    = v.redir_pc;
    endtask

    task automatic idle_inputs();
        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rresp      = 2'b00;
        bus.rdata      = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        // Main sequence: fetch, backpressure, redirects in every state, errors.
        seg1.push_back(mk(6'b100000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0000, 0, 0, 0));
        seg1.push_back(mk(6'b010000, 32'h0000_0413, 0, E_DATA, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            seg1.push_back(mk(6'b000000, 0, 0, E_VALID, 0, 32'h0000_0413, 32'h8000_0000, 2'b00));
        seg1.push_back(mk(6'b000010, 0, 0, E_VALID, 0, 32'h0000_0413, 32'h8000_0000, 2'b00));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            seg1.push_back(mk(6'b000000, 0, 0, E_ADDR, 32'h8000_0004, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0004, 0, 0, 0));
        seg1.push_back(mk(6'b000001, 0, 32'h8000_0100, E_DATA, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_DRAIN, 0, 0, 0, 0));
        seg1.push_back(mk(6'b010000, 32'hDEAD_BEEF, 0, E_DRAIN, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000001, 0, 32'h8000_0200, E_ADDR, 32'h8000_0100, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_ADDR, 32'h8000_0100, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0100, 0, 0, 0));
        seg1.push_back(mk(6'b010000, 32'hCAFE_F00D, 0, E_DRAIN, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0200, 0, 0, 0));
        seg1.push_back(mk(6'b011000, 32'h1234_5678, 0, E_DATA, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000001, 0, 32'h8000_0102, E_VALID, 0, 32'h0, 32'h8000_0200, 2'b01));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000010, 0, 0, E_VALID, 0, 32'h0, 32'h8000_0102, 2'b10));
        seg1.push_back(mk(6'b000001, 0, 32'h8000_0300, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0300, 0, 0, 0));
        seg1.push_back(mk(6'b010001, 32'h0010_0073, 32'h8000_0400, E_DATA, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0400, 0, 0, 0));
        seg1.push_back(mk(6'b010000, 32'hAABB_CCDD, 0, E_DATA, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000011, 0, 32'h8000_0500, E_VALID, 0, 32'hAABB_CCDD, 32'h8000_0400, 2'b00));
        seg1.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg1.push_back(mk(6'b000000, 0, 0, E_ADDR, 32'h8000_0500, 0, 0, 0));

        // After a mid-fetch reset: restart at RESET_PC, then wrap from the top of memory.
        seg2.push_back(mk(6'b100000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg2.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'h8000_0000, 0, 0, 0));
        seg2.push_back(mk(6'b010000, 32'h0000_0013, 0, E_DATA, 0, 0, 0, 0));
        seg2.push_back(mk(6'b000011, 0, 32'hFFFF_FFFC, E_VALID, 0, 32'h0000_0013, 32'h8000_0000, 2'b00));
        seg2.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg2.push_back(mk(6'b100000, 0, 0, E_ADDR, 32'hFFFF_FFFC, 0, 0, 0));
        seg2.push_back(mk(6'b010000, 32'h0000_006F, 0, E_DATA, 0, 0, 0, 0));
        seg2.push_back(mk(6'b000010, 0, 0, E_VALID, 0, 32'h0000_006F, 32'hFFFF_FFFC, 2'b00));
        seg2.push_back(mk(6'b000000, 0, 0, E_IDLE, 0, 0, 0, 0));
        seg2.push_back(mk(6'b000000, 0, 0, E_ADDR, 32'h0000_0000, 0, 0, 0));

        idle_inputs();
        bus.rlast = 1'b1;
        bus.rid   = 4'd0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset arvalid", {31'd0, bus.arvalid}, 32'd0);
        check("reset rready", {31'd0, bus.rready}, 32'd0);
        check("reset inst_valid", {31'd0, inst_valid}, 32'd0);
        check("reset inst", inst, 32'd0);
        check("reset inst_pc", inst_pc, 32'd0);
        check("reset inst_err", {30'd0, inst_err}, 32'd0);
        check("reset fetch_busy", {31'd0, fetch_busy}, 32'd0);
        check("const arid", {28'd0, bus.arid}, 32'd0);
        check("const arlen", {24'd0, bus.arlen}, 32'd0);
        check("const arsize", {29'd0, bus.arsize}, 32'd2);
        check("const arburst", {30'd0, bus.arburst}, 32'd1);
        $display("[TB] reset state checked");

        reset    = 1'b1;
        ar_count = 0;
        for (int i = 0; i < seg1.size(); i++) begin
            apply("main", i, seg1[i]);
            @(posedge clock);
            @(negedge clock);
        end
        check("AR handshake count", ar_count, 32'd6);

        // Accept the pending AR so the block sits in DATA, then pull reset mid-cycle.
        bus.arready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.arready = 1'b0;
        check("pre-reset rready in DATA", {31'd0, bus.rready}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async reset arvalid", {31'd0, bus.arvalid}, 32'd0);
        check("async reset rready", {31'd0, bus.rready}, 32'd0);
        check("async reset inst_valid", {31'd0, inst_valid}, 32'd0);
        check("async reset inst", inst, 32'd0);
        check("async reset inst_pc", inst_pc, 32'd0);
        check("async reset inst_err", {30'd0, inst_err}, 32'd0);
        check("async reset fetch_busy", {31'd0, fetch_busy}, 32'd0);
        $display("[TB] asynchronous reset in DATA checked");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < seg2.size(); i++) begin
            apply("restart", i, seg2[i]);
            @(posedge clock);
            @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule

// File: doc/ifu_axi_fetch.md
Name: ifu_axi_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle RV32 execute/decode core.
- Owns the PC and fetches one 32-bit instruction per access over an AXI4 read-only master (single-beat INCR).
- Presents the instruction to the core through a valid/ready handshake, and accepts a redirect (taken branch, jump, ecall, mret) from the core.
- Discards any in-flight fetch that the redirect makes stale, without violating AXI ordering.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
AXI_ID, 4'd0, constant arid value

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (low = in reset)
io_master_arready  in  1  AR channel ready
io_master_arvalid  out  1  AR channel valid
io_master_araddr  out  32  fetch address (= pc)
io_master_arid  out  4  constant AXI_ID
io_master_arlen  out  8  constant 0
io_master_arsize  out  3  constant 3'b010
io_master_arburst  out  2  constant 2'b01 (INCR)
io_master_rready  out  1  R channel ready
io_master_rvalid  in  1  R channel valid
io_master_rdata  in  32  read data
io_master_rresp  in  2  read response
io_master_rlast  in  1  unused (single beat)
io_master_rid  in  4  unused
inst_valid  out  1  inst/inst_pc/inst_err valid to core
inst_ready  in  1  core consumes instruction
inst  out  32  fetched instruction (0 when inst_err != 0)
inst_pc  out  32  PC of inst
inst_err  out  2  00 ok, 01 bus error (rresp != OKAY), 10 misaligned PC
redirect_valid  in  1  core requests PC change
redirect_pc  in  32  new PC
fetch_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, async):
  - state = IDLE, pc = RESET_PC.
  - arvalid, rready, inst_valid = 0; inst, inst_pc, inst_err = 0.
- States: IDLE, ADDR, DATA, VALID, DRAIN.
- IDLE: one cycle, no bus activity.
  - If pc[1:0] != 0: go to VALID with inst_err = 10, inst = 0, inst_pc = pc. No AXI access.
  - Otherwise: go to ADDR.
- ADDR: arvalid = 1, araddr = pc.
  - araddr and arvalid stay stable until arready.
  - On arready: go to DATA, or to DRAIN if the kill flag is set.
- DATA: rready = 1.
  - On rvalid: latch rdata into inst and pc into inst_pc.
  - inst_err = 01 if rresp != 2'b00; in that case inst = 0.
  - Then go to VALID.
- VALID: inst_valid = 1; outputs held stable until consumed.
  - On inst_ready: pc <= pc + 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), go to IDLE.
- DRAIN: rready = 1.
  - On rvalid: drop the data, go to IDLE.
- Redirect (redirect_valid sampled each cycle):
  - IDLE: pc <= redirect_pc; the IDLE decision next cycle uses the new pc.
  - ADDR: pc <= redirect_pc; set kill flag. arvalid must not be withdrawn, so keep old araddr until arready, then go to DRAIN. Kill flag clears on entering DRAIN.
  - DATA: pc <= redirect_pc. If rvalid in the same cycle, drop the data and go to IDLE; else go to DRAIN.
  - VALID with inst_ready: instruction counts as consumed; pc <= redirect_pc (not pc+4); go to IDLE.
  - VALID without inst_ready: instruction is dropped; inst_valid = 0 next cycle; pc <= redirect_pc; go to IDLE.
  - DRAIN: pc <= redirect_pc; remain in DRAIN until rvalid.
  - Redirect always wins over the pc+4 update.
- Latency: with arready and rvalid asserted immediately, inst_valid rises 3 cycles after entering IDLE. Sustained rate is one instruction per 4 cycles.
- At most one outstanding AR transaction at any time.
- rvalid outside DATA/DRAIN is ignored; rready = 0 there.
- Reset asserted mid-transaction returns the block to reset state immediately. The interconnect is reset by the same signal.

Decomposition:
- Shared package ifu_pkg:
  - state enum (IDLE, ADDR, DATA, VALID, DRAIN)
  - INST_ERR_OK/BUS/MISALIGN codes
  - AXI constants: BURST_INCR = 2'b01, SIZE_4B = 3'b010, RESP_OKAY = 2'b00
- Single module; no sub-module. The PC/next-PC mux and the FSM are small enough to stay in one file.

Test Plan:
- Reset release, arready=1, rvalid next cycle with rdata=32'h00000413 -> araddr=32'h8000_0000; inst_valid 3 cycles after IDLE; inst=32'h00000413, inst_pc=32'h8000_0000, inst_err=00.
- arready held low 3 cycles -> arvalid stays 1 and araddr constant all 4 cycles; one AR handshake only.
- inst_ready low 5 cycles in VALID -> inst/inst_pc stable, no new AR. Then ready=1 -> next araddr = 32'h8000_0004.
- redirect_valid with redirect_pc=32'h8000_0100 while in DATA, rvalid 2 cycles later -> data dropped, inst_valid never asserts for it; next araddr = 32'h8000_0100.
- redirect in ADDR with arready low -> old araddr held until arready; then DRAIN consumes the R beat; next araddr = redirect_pc.
- rresp=2'b10 -> inst_err=01, inst=0. Redirect to 32'h8000_0102 -> no AR issued; inst_valid with inst_err=10, inst_pc=32'h8000_0102.
- reset pulled low while in DATA -> all outputs 0 asynchronously; after release, fetch restarts at RESET_PC.
